// File: rtl/ym_arb_pkg.sv
// Shared types and default timing for the YM2151 bus arbiter.
package ym_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT
  } state_t;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_UART = 1'b1
  } gnt_t;

  localparam int YM_STROBE_PM = 2;
  localparam int YM_ADDR_WAIT = 2;
  localparam int YM_DATA_WAIT = 68;

endpackage

// File: rtl/ym_pm_timer.sv
// phi-M rising-edge detector plus a down-counter that steps once per phi-M edge.
// The counter stops at zero; a load takes priority over the decrement.
module ym_pm_timer #(
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ym_pm,
  input  logic              load,
  input  logic [WAIT_W-1:0] value,
  output logic              pm_edge,
  output logic              zero
);

  logic              pm_last;
  logic [WAIT_W-1:0] cnt;

  assign pm_edge = ym_pm & ~pm_last;
  assign zero    = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_last <= 1'b0;
      cnt     <= '0;
    end else begin
      pm_last <= ym_pm;
      if (load)
        cnt <= value;
      else if (pm_edge && !zero)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ym_bus_arb.sv
// Two-requester (CPU, UART) sequencer for the YM2151 register port, paced by phi-M.
// Tie policy: fixed CPU priority by default; round-robin when YM_ARB_RR_EN is defined.
module ym_bus_arb
  import ym_arb_pkg::*;
#(
  parameter int STROBE_PM = YM_STROBE_PM,
  parameter int ADDR_WAIT = YM_ADDR_WAIT,
  parameter int DATA_WAIT = YM_DATA_WAIT,
  parameter int WAIT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ym_pm,
  input  logic       cpu_req,
  input  logic       cpu_wr,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_din,
  output logic       cpu_ack,
  output logic [7:0] cpu_dout,
  input  logic       uart_req,
  input  logic       uart_wr,
  input  logic       uart_a0,
  input  logic [7:0] uart_din,
  output logic       uart_ack,
  output logic [7:0] uart_dout,
  output logic       ym_cs_n,
  output logic       ym_wr_n,
  output logic       ym_rd_n,
  output logic       ym_a0,
  output logic [7:0] ym_dout,
  input  logic [7:0] ym_din,
  output logic       busy
);

  // Counters are loaded with N-1 so "pm_edge while zero" marks the N-th edge.
  localparam logic [WAIT_W-1:0] STB_LD = WAIT_W'(STROBE_PM - 1);
  localparam logic [WAIT_W-1:0] ADDR_W = WAIT_W'(ADDR_WAIT);
  localparam logic [WAIT_W-1:0] DATA_W = WAIT_W'(DATA_WAIT);

  state_t            state, state_nx;
  gnt_t              gnt;
  logic              wr_q;
  logic              pm_edge, cnt_zero, cnt_load, done;
  logic              strobe_on, strobe_off;
  logic              grant_any, grant_cpu;
  logic [WAIT_W-1:0] cnt_val, wait_len;

  ym_pm_timer #(.WAIT_W(WAIT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .ym_pm   (ym_pm),
    .load    (cnt_load),
    .value   (cnt_val),
    .pm_edge (pm_edge),
    .zero    (cnt_zero)
  );

`ifdef YM_ARB_RR_EN
  gnt_t last_gnt;

  always_ff @(posedge clk) begin
    if (rst)
      last_gnt <= GNT_UART;
    else if (state == ST_IDLE && grant_any)
      last_gnt <= grant_cpu ? GNT_CPU : GNT_UART;
  end

  assign grant_cpu = cpu_req & (~uart_req | (last_gnt == GNT_UART));
`else
  assign grant_cpu = cpu_req;
`endif

  assign grant_any = cpu_req | uart_req;
  assign done      = pm_edge & cnt_zero;
  assign wait_len  = !wr_q ? '0 : (ym_a0 ? DATA_W : ADDR_W);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (grant_any) state_nx = ST_SETUP;
      ST_SETUP:  if (pm_edge)   state_nx = ST_STROBE;
      ST_STROBE: if (done)      state_nx = (wait_len == '0) ? ST_IDLE : ST_WAIT;
      ST_WAIT:   if (done)      state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    strobe_on  = (state == ST_SETUP) && pm_edge;
    strobe_off = (state == ST_STROBE) && done;
    cnt_load   = 1'b0;
    cnt_val    = STB_LD;
    if (strobe_on) begin
      cnt_load = 1'b1;
    end else if (strobe_off && wait_len != '0) begin
      cnt_load = 1'b1;
      cnt_val  = wait_len - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ym_cs_n   <= 1'b1;
      ym_wr_n   <= 1'b1;
      ym_rd_n   <= 1'b1;
      ym_a0     <= 1'b0;
      ym_dout   <= 8'h00;
      cpu_ack   <= 1'b0;
      uart_ack  <= 1'b0;
      cpu_dout  <= 8'h00;
      uart_dout <= 8'h00;
      gnt       <= GNT_CPU;
      wr_q      <= 1'b0;
    end else begin
      cpu_ack  <= 1'b0;
      uart_ack <= 1'b0;
      if (state == ST_IDLE && grant_any) begin
        gnt     <= grant_cpu ? GNT_CPU : GNT_UART;
        wr_q    <= grant_cpu ? cpu_wr  : uart_wr;
        ym_a0   <= grant_cpu ? cpu_a0  : uart_a0;
        ym_dout <= grant_cpu ? cpu_din : uart_din;
      end
      if (strobe_on) begin
        ym_cs_n <= 1'b0;
        ym_wr_n <= ~wr_q;
        ym_rd_n <= wr_q;
      end
      if (strobe_off) begin
        ym_cs_n <= 1'b1;
        ym_wr_n <= 1'b1;
        ym_rd_n <= 1'b1;
        if (gnt == GNT_CPU) begin
          cpu_ack <= 1'b1;
          if (!wr_q) cpu_dout <= ym_din;
        end else begin
          uart_ack <= 1'b1;
          if (!wr_q) uart_dout <= ym_din;
        end
      end
    end
  end

endmodule

// File: tb/tb_ym_bus_arb.sv
// Directed bench for ym_bus_arb; phi-M is a 5-clk period enable (high 2 of 5).
module tb_ym_bus_arb;

  logic       clk = 1'b0, rst = 1'b1, ym_pm = 1'b0;
  logic       cpu_req = 0, cpu_wr = 0, cpu_a0 = 0;
  logic [7:0] cpu_din = 8'h00;
  logic       uart_req = 0, uart_wr = 0, uart_a0 = 0;
  logic [7:0] uart_din = 8'h00, ym_din = 8'h00;
  logic       cpu_ack, uart_ack, ym_cs_n, ym_wr_n, ym_rd_n, ym_a0, busy;
  logic [7:0] cpu_dout, uart_dout, ym_dout;

  ym_bus_arb dut (
    .clk(clk), .rst(rst), .ym_pm(ym_pm),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a0(cpu_a0), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .uart_req(uart_req), .uart_wr(uart_wr), .uart_a0(uart_a0), .uart_din(uart_din),
    .uart_ack(uart_ack), .uart_dout(uart_dout),
    .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n), .ym_rd_n(ym_rd_n),
    .ym_a0(ym_a0), .ym_dout(ym_dout), .ym_din(ym_din), .busy(busy)
  );

  always #5 clk = ~clk;

  int pm_cnt = 0;
  always @(posedge clk) begin
    #1;
    ym_pm  = (pm_cnt < 2);
    pm_cnt = (pm_cnt + 1) % 5;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bus monitor: strobe widths, data on the bus, ack/busy timestamps, grant order.
  int cyc = 0, wr_run = 0, rd_run = 0, wr_len = 0, rd_len = 0;
  int cs_fall = 0, busy_fall = 0, cpu_ack_cyc = 0, cpu_acks = 0, uart_acks = 0;
  logic [7:0] wr_data = 8'h00;
  logic prev_cs = 1'b1, prev_busy = 1'b0;
  int order[$];

  always @(negedge clk) begin
    cyc++;
    if (!ym_wr_n) begin wr_run++; wr_data = ym_dout; end
    else if (wr_run != 0) begin wr_len = wr_run; wr_run = 0; end
    if (!ym_rd_n) rd_run++;
    else if (rd_run != 0) begin rd_len = rd_run; rd_run = 0; end
    if (prev_cs && !ym_cs_n) cs_fall = cyc;
    prev_cs = ym_cs_n;
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
    if (cpu_ack)  begin cpu_acks++; cpu_ack_cyc = cyc; order.push_back(0); end
    if (uart_ack) begin uart_acks++; order.push_back(1); end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit who, input string tag);
    int n = 0;
    while (!(who ? uart_ack : cpu_ack) && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int a0, a1, n, cpu_left, uart_left;
    int exp_ord[4];
`ifdef YM_ARB_RR_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 1, 1};
`endif
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_strobes", 32'({ym_cs_n, ym_wr_n, ym_rd_n}), 32'b111);
    chk("rst_busy_ack", 32'({busy, cpu_ack, uart_ack}), 32'b000);
    chk("rst_ym_bus", 32'({ym_a0, ym_dout}), 32'h000);
    chk("rst_douts", 32'({cpu_dout, uart_dout}), 32'h0000);
    tick();

    // CPU data write: 10-clk strobe, one ack, 68 pm edges (340 clk) of busy after ack
    a0 = cpu_acks;
    cpu_wr = 1; cpu_a0 = 1; cpu_din = 8'h5A; cpu_req = 1;
    wait_ack(0, "dw_ack");
    cpu_req = 0;
    wait_idle("dw_idle");
    tick();
    chk("dw_wr_len", 32'(wr_len), 32'd10);
    chk("dw_ym_dout", 32'(wr_data), 32'h5A);
    chk("dw_ym_a0", 32'(ym_a0), 32'd1);
    chk("dw_acks", 32'(cpu_acks - a0), 32'd1);
    chk("dw_busy_wait", 32'(busy_fall - cpu_ack_cyc), 32'd340);

    // UART read: no WAIT phase
    ym_din = 8'h80; uart_wr = 0; uart_a0 = 1; uart_req = 1;
    wait_ack(1, "rd_ack");
    chk("rd_uart_dout", 32'(uart_dout), 32'h80);
    chk("rd_busy_at_ack", 32'(busy), 32'd0);
    uart_req = 0;
    tick();
    chk("rd_rd_len", 32'(rd_len), 32'd10);
    chk("rd_cpu_dout", 32'(cpu_dout), 32'h00);

    // Both requesting, two address writes each
    order.delete();
    cpu_wr = 1; cpu_a0 = 0; cpu_din = 8'h01;
    uart_wr = 1; uart_a0 = 0; uart_din = 8'h02;
    cpu_left = 2; uart_left = 2; cpu_req = 1; uart_req = 1;
    n = 0;
    while ((cpu_left != 0 || uart_left != 0) && n < 5000) begin
      tick(); n++;
      if (cpu_ack)  begin cpu_left--;  if (cpu_left == 0)  cpu_req = 0;  end
      if (uart_ack) begin uart_left--; if (uart_left == 0) uart_req = 0; end
    end
    if (n >= 5000) chk("tie_timeout", 32'd0, 32'd1);
    wait_idle("tie_idle");
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_order_%0d", i), 32'(order.size() > i ? order[i] : 9), 32'(exp_ord[i]));

    // Address write then data write: next cs fall >= 2 pm periods after ack
    tick();
    cpu_wr = 1; cpu_a0 = 0; cpu_din = 8'h20; cpu_req = 1;
    wait_ack(0, "aw_ack1");
    a1 = cpu_ack_cyc;
    cpu_a0 = 1; cpu_din = 8'h33;
    tick();
    wait_ack(0, "aw_ack2");
    cpu_req = 0;
    chk("aw_gap", 32'((cs_fall - a1) >= 10), 32'd1);
    chk("aw_data", 32'(wr_data), 32'h33);
    wait_idle("aw_idle");

    // Reset during WAIT
    tick();
    cpu_wr = 1; cpu_a0 = 1; cpu_din = 8'h11; cpu_req = 1;
    wait_ack(0, "rw_ack");
    cpu_req = 0;
    repeat (20) tick();
    chk("rw_in_wait", 32'(busy), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rw_after", 32'({ym_cs_n, ym_wr_n, ym_rd_n, busy, cpu_ack, uart_ack}), 32'b111000);
    chk("rw_ym_dout", 32'(ym_dout), 32'h00);

    // Reset during STROBE: no ack afterwards
    a0 = cpu_acks;
    cpu_wr = 1; cpu_a0 = 1; cpu_din = 8'h44; cpu_req = 1;
    n = 0;
    while (ym_wr_n && n < 200) begin tick(); n++; end
    if (n >= 200) chk("rs_strobe_timeout", 32'd0, 32'd1);
    tick();
    rst = 1; cpu_req = 0;
    tick();
    rst = 0;
    chk("rs_after", 32'({ym_cs_n, ym_wr_n, ym_rd_n, busy, cpu_ack, uart_ack}), 32'b111000);
    repeat (30) tick();
    chk("rs_no_ack", 32'(cpu_acks - a0), 32'd0);

    // Normal service after reset
    ym_din = 8'hC3; cpu_wr = 0; cpu_a0 = 1; cpu_req = 1;
    wait_ack(0, "pr_ack");
    chk("pr_cpu_dout", 32'(cpu_dout), 32'hC3);
    cpu_req = 0;
    wait_idle("pr_idle");

    // Request dropped in SETUP still completes with one ack
    tick();
    a0 = cpu_acks;
    cpu_wr = 1; cpu_a0 = 0; cpu_din = 8'h7E; cpu_req = 1;
    n = 0;
    while (!busy && n < 50) begin tick(); n++; end
    if (n >= 50) chk("dr_grant_timeout", 32'd0, 32'd1);
    cpu_req = 0;
    wait_ack(0, "dr_ack");
    tick();
    wait_idle("dr_idle");
    tick();
    chk("dr_acks", 32'(cpu_acks - a0), 32'd1);
    chk("dr_data", 32'(wr_data), 32'h7E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
